// File: rtl/vga_cfg_pkg.sv
// Shared constants and types for the VGA configuration register file:
// register map, bit positions, 640x480@60 defaults and the timing-set layout.
package vga_cfg_pkg;

    localparam int TIM_HW = 12;
    localparam int TIM_VW = 11;

    localparam logic [31:0] OFF_CTRL      = 32'h0000_0000;
    localparam logic [31:0] OFF_BASE      = 32'h0000_0004;
    localparam logic [31:0] OFF_SIZE      = 32'h0000_0008;
    localparam logic [31:0] OFF_STATUS    = 32'h0000_000C;
    localparam logic [31:0] OFF_IRQ_EN    = 32'h0000_0010;
    localparam logic [31:0] OFF_COMMIT    = 32'h0000_0014;
    localparam logic [31:0] OFF_MODE_BASE = 32'h0000_0100;
    localparam int          MODE_STRIDE   = 16;

    localparam int CTRL_SELF_TEST = 0;
    localparam int CTRL_SYNC_EN   = 1;
    localparam int CTRL_MODE_LSB  = 8;
    localparam int STAT_PENDING   = 0;
    localparam int STAT_APPLIED   = 1;

    localparam int DEF_HSYNC_END   = 799;
    localparam int DEF_HPULSE_END  = 95;
    localparam int DEF_HDATA_BEGIN = 143;
    localparam int DEF_HDATA_END   = 783;
    localparam int DEF_VSYNC_END   = 524;
    localparam int DEF_VPULSE_END  = 1;
    localparam int DEF_VDATA_BEGIN = 34;
    localparam int DEF_VDATA_END   = 514;

    localparam logic [31:0] DEF_H0 = {16'(DEF_HPULSE_END), 16'(DEF_HSYNC_END)};
    localparam logic [31:0] DEF_H1 = {16'(DEF_HDATA_END),  16'(DEF_HDATA_BEGIN)};
    localparam logic [31:0] DEF_V0 = {16'(DEF_VPULSE_END), 16'(DEF_VSYNC_END)};
    localparam logic [31:0] DEF_V1 = {16'(DEF_VDATA_END),  16'(DEF_VDATA_BEGIN)};

    typedef struct packed {
        logic [TIM_HW-1:0] hsync_end;
        logic [TIM_HW-1:0] hpulse_end;
        logic [TIM_HW-1:0] hdata_begin;
        logic [TIM_HW-1:0] hdata_end;
        logic [TIM_VW-1:0] vsync_end;
        logic [TIM_VW-1:0] vpulse_end;
        logic [TIM_VW-1:0] vdata_begin;
        logic [TIM_VW-1:0] vdata_end;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        hsync_end:   TIM_HW'(DEF_HSYNC_END),
        hpulse_end:  TIM_HW'(DEF_HPULSE_END),
        hdata_begin: TIM_HW'(DEF_HDATA_BEGIN),
        hdata_end:   TIM_HW'(DEF_HDATA_END),
        vsync_end:   TIM_VW'(DEF_VSYNC_END),
        vpulse_end:  TIM_VW'(DEF_VPULSE_END),
        vdata_begin: TIM_VW'(DEF_VDATA_BEGIN),
        vdata_end:   TIM_VW'(DEF_VDATA_END)
    };

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} apb_state_t;

endpackage

// File: rtl/vga_cfg_regfile_if.sv
// APB slave bundle for the VGA configuration register file.
interface vga_cfg_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [DATA_WIDTH-1:0] pwdata_i;
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic                  pready_o;
    logic [DATA_WIDTH-1:0] prdata_o;
    logic                  pslverr_o;

    modport master (
        output paddr_i, pwdata_i, psel_i, penable_i, pwrite_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  paddr_i, pwdata_i, psel_i, penable_i, pwrite_i,
        output pready_o, prdata_o, pslverr_o
    );
endinterface

// File: rtl/vga_cfg_mode_table.sv
// Staged timing preset storage: NUM_MODES x 4 words, APB read port and a
// mode_sel-indexed timing set feeding the active shadows.
module vga_cfg_mode_table
    import vga_cfg_pkg::*;
#(
    parameter int NUM_MODES = 4,
    localparam int MODE_W = $clog2(NUM_MODES)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [MODE_W-1:0] wr_mode,
    input  logic [1:0]        wr_word,
    input  logic [31:0]       wr_data,
    input  logic [MODE_W-1:0] rd_mode,
    input  logic [1:0]        rd_word,
    output logic [31:0]       rd_data,
    input  logic [MODE_W-1:0] sel_mode,
    output timing_t           sel_set
);

    localparam logic [15:0] H_MASK = 16'((32'd1 << TIM_HW) - 1);
    localparam logic [15:0] V_MASK = 16'((32'd1 << TIM_VW) - 1);

    logic [31:0] mem [NUM_MODES][4];

    // Words 0/1 hold horizontal pairs, words 2/3 vertical pairs.
    function automatic logic [31:0] word_mask(input logic [1:0] w);
        return w[1] ? {V_MASK, V_MASK} : {H_MASK, H_MASK};
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int m = 0; m < NUM_MODES; m++) begin
                mem[m][0] <= DEF_H0;
                mem[m][1] <= DEF_H1;
                mem[m][2] <= DEF_V0;
                mem[m][3] <= DEF_V1;
            end
        end else if (wr_en) begin
            mem[wr_mode][wr_word] <= wr_data & word_mask(wr_word);
        end
    end

    assign rd_data = mem[rd_mode][rd_word];

    always_comb begin
        sel_set             = DEF_TIMING;
        sel_set.hsync_end   = mem[sel_mode][0][TIM_HW-1:0];
        sel_set.hpulse_end  = mem[sel_mode][0][16 +: TIM_HW];
        sel_set.hdata_begin = mem[sel_mode][1][TIM_HW-1:0];
        sel_set.hdata_end   = mem[sel_mode][1][16 +: TIM_HW];
        sel_set.vsync_end   = mem[sel_mode][2][TIM_VW-1:0];
        sel_set.vpulse_end  = mem[sel_mode][2][16 +: TIM_VW];
        sel_set.vdata_begin = mem[sel_mode][3][TIM_VW-1:0];
        sel_set.vdata_end   = mem[sel_mode][3][16 +: TIM_VW];
    end

endmodule

// File: rtl/vga_cfg_regfile.sv
// APB configuration register file for the VGA pipeline; staged settings are
// copied into active shadows at a frame boundary or immediately on async commit.
module vga_cfg_regfile
    import vga_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_MODES  = 4,
    parameter int HW         = TIM_HW,
    parameter int VW         = TIM_VW,
    localparam int MODE_W    = $clog2(NUM_MODES)
) (
    input  logic                  clk,
    input  logic                  resetn,
    vga_cfg_regfile_if.slave      apb,
    input  logic                  frame_start_i,
    output logic [HW-1:0]         hsync_end_o,
    output logic [HW-1:0]         hpulse_end_o,
    output logic [HW-1:0]         hdata_begin_o,
    output logic [HW-1:0]         hdata_end_o,
    output logic [VW-1:0]         vsync_end_o,
    output logic [VW-1:0]         vpulse_end_o,
    output logic [VW-1:0]         vdata_begin_o,
    output logic [VW-1:0]         vdata_end_o,
    output logic [ADDR_WIDTH-1:0] base_addr_o,
    output logic [ADDR_WIDTH-1:0] top_addr_o,
    output logic                  self_test_o,
    output logic                  irq_o
);

    localparam logic [ADDR_WIDTH-1:0] MODE_LO = ADDR_WIDTH'(OFF_MODE_BASE);
    localparam logic [ADDR_WIDTH-1:0] MODE_HI = ADDR_WIDTH'(OFF_MODE_BASE + 32'(MODE_STRIDE * NUM_MODES));

    apb_state_t state;
    logic [ADDR_WIDTH-1:0] addr;
    logic hit_ctrl, hit_base, hit_size, hit_status, hit_irq_en, hit_commit, hit_mode, dec_err;
    logic [MODE_W-1:0] mode_idx;
    logic [DATA_WIDTH-1:0] rd_word, ctrl_word, mode_rd;
    logic wr_fire, commit_wr, commit_sync, apply_sync, apply, async_req;
    logic ctrl_self_test, ctrl_sync_en, pending, applied, irq_en;
    logic [MODE_W-1:0] ctrl_mode_sel;
    logic [ADDR_WIDTH-1:0] base, size;
    timing_t sel_set, act_tim_p0, out_tim_p1;
    logic [ADDR_WIDTH-1:0] act_base_p0, act_size_p0;
    logic act_self_test_p0;

    assign addr       = apb.paddr_i;
    assign hit_ctrl   = (addr == ADDR_WIDTH'(OFF_CTRL));
    assign hit_base   = (addr == ADDR_WIDTH'(OFF_BASE));
    assign hit_size   = (addr == ADDR_WIDTH'(OFF_SIZE));
    assign hit_status = (addr == ADDR_WIDTH'(OFF_STATUS));
    assign hit_irq_en = (addr == ADDR_WIDTH'(OFF_IRQ_EN));
    assign hit_commit = (addr == ADDR_WIDTH'(OFF_COMMIT));
    assign hit_mode   = (addr >= MODE_LO) && (addr < MODE_HI);
    assign dec_err    = (addr[1:0] != 2'b00) ||
                        !(hit_ctrl || hit_base || hit_size || hit_status ||
                          hit_irq_en || hit_commit || hit_mode);
    // The mode region starts on a 16-byte boundary, so the index is a narrow subtract.
    assign mode_idx   = addr[4 +: MODE_W] - MODE_W'(OFF_MODE_BASE >> 4);

    always_comb begin
        ctrl_word                          = '0;
        ctrl_word[CTRL_SELF_TEST]          = ctrl_self_test;
        ctrl_word[CTRL_SYNC_EN]            = ctrl_sync_en;
        ctrl_word[CTRL_MODE_LSB +: MODE_W] = ctrl_mode_sel;
    end

    always_comb begin
        rd_word = '0;
        if (!dec_err) begin
            if (hit_ctrl)        rd_word = ctrl_word;
            else if (hit_base)   rd_word = DATA_WIDTH'(base);
            else if (hit_size)   rd_word = DATA_WIDTH'(size);
            else if (hit_status) rd_word = DATA_WIDTH'({applied, pending});
            else if (hit_irq_en) rd_word = DATA_WIDTH'(irq_en);
            else if (hit_mode)   rd_word = mode_rd;
        end
    end

    // APB: setup in IDLE, first access cycle in WAIT, completion in ACK.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            apb.pready_o  <= 1'b0;
            apb.prdata_o  <= '0;
            apb.pslverr_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    apb.pready_o  <= 1'b0;
                    apb.prdata_o  <= '0;
                    apb.pslverr_o <= 1'b0;
                    if (apb.psel_i && !apb.penable_i) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (apb.psel_i && apb.penable_i) begin
                        state         <= ST_ACK;
                        apb.pready_o  <= 1'b1;
                        apb.prdata_o  <= rd_word;
                        apb.pslverr_o <= dec_err;
                    end else if (!apb.psel_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    state         <= ST_IDLE;
                    apb.pready_o  <= 1'b0;
                    apb.prdata_o  <= '0;
                    apb.pslverr_o <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wr_fire     = (state == ST_ACK) && apb.psel_i && apb.penable_i && apb.pwrite_i && !dec_err;
    assign commit_wr   = wr_fire && hit_commit && apb.pwdata_i[0];
    assign commit_sync = commit_wr && ctrl_sync_en;
    // A commit landing on a frame pulse re-arms pending instead of applying.
    assign apply_sync  = frame_start_i && pending && !commit_sync;
    assign apply       = apply_sync || async_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_self_test <= 1'b0;
            ctrl_sync_en   <= 1'b0;
            ctrl_mode_sel  <= '0;
            base           <= '0;
            size           <= '0;
            irq_en         <= 1'b0;
            pending        <= 1'b0;
            applied        <= 1'b0;
            async_req      <= 1'b0;
        end else begin
            if (wr_fire && hit_ctrl) begin
                ctrl_self_test <= apb.pwdata_i[CTRL_SELF_TEST];
                ctrl_sync_en   <= apb.pwdata_i[CTRL_SYNC_EN];
                ctrl_mode_sel  <= apb.pwdata_i[CTRL_MODE_LSB +: MODE_W];
            end
            if (wr_fire && hit_base)   base   <= apb.pwdata_i[ADDR_WIDTH-1:0];
            if (wr_fire && hit_size)   size   <= apb.pwdata_i[ADDR_WIDTH-1:0];
            if (wr_fire && hit_irq_en) irq_en <= apb.pwdata_i[0];
            async_req <= commit_wr && !ctrl_sync_en;
            if (commit_sync)  pending <= 1'b1;
            else if (apply)   pending <= 1'b0;
            if (apply)        applied <= 1'b1;
            else if (wr_fire && hit_status && apb.pwdata_i[STAT_APPLIED]) applied <= 1'b0;
        end
    end

    vga_cfg_mode_table #(.NUM_MODES(NUM_MODES)) u_mode_table (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_fire && hit_mode),
        .wr_mode  (mode_idx),
        .wr_word  (addr[3:2]),
        .wr_data  (apb.pwdata_i),
        .rd_mode  (mode_idx),
        .rd_word  (addr[3:2]),
        .rd_data  (mode_rd),
        .sel_mode (ctrl_mode_sel),
        .sel_set  (sel_set)
    );

    // p0: active shadows captured on apply; p1: registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act_tim_p0       <= DEF_TIMING;
            act_base_p0      <= '0;
            act_size_p0      <= '0;
            act_self_test_p0 <= 1'b0;
            out_tim_p1       <= DEF_TIMING;
            base_addr_o      <= '0;
            top_addr_o       <= '0;
            self_test_o      <= 1'b0;
        end else begin
            if (apply) begin
                act_tim_p0       <= sel_set;
                act_base_p0      <= base;
                act_size_p0      <= size;
                act_self_test_p0 <= ctrl_self_test;
            end
            out_tim_p1  <= act_tim_p0;
            base_addr_o <= act_base_p0;
            top_addr_o  <= act_base_p0 + act_size_p0;
            self_test_o <= act_self_test_p0;
        end
    end

    assign hsync_end_o   = HW'(out_tim_p1.hsync_end);
    assign hpulse_end_o  = HW'(out_tim_p1.hpulse_end);
    assign hdata_begin_o = HW'(out_tim_p1.hdata_begin);
    assign hdata_end_o   = HW'(out_tim_p1.hdata_end);
    assign vsync_end_o   = VW'(out_tim_p1.vsync_end);
    assign vpulse_end_o  = VW'(out_tim_p1.vpulse_end);
    assign vdata_begin_o = VW'(out_tim_p1.vdata_begin);
    assign vdata_end_o   = VW'(out_tim_p1.vdata_end);
    assign irq_o         = applied & irq_en;

endmodule

// File: tb/tb_vga_cfg_regfile.sv
// Directed bench for vga_cfg_regfile: register map, staged/active commit paths,
// APB wait-state timing, error decode and asynchronous reset.
module tb_vga_cfg_regfile;

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_start_i;
    logic [11:0] hsync_end_o, hpulse_end_o, hdata_begin_o, hdata_end_o;
    logic [10:0] vsync_end_o, vpulse_end_o, vdata_begin_o, vdata_end_o;
    logic [31:0] base_addr_o, top_addr_o;
    logic        self_test_o, irq_o;

    int checks = 0;
    int failures = 0;

    vga_cfg_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

    vga_cfg_regfile dut (
        .clk           (clk),
        .resetn        (resetn),
        .apb           (apb),
        .frame_start_i (frame_start_i),
        .hsync_end_o   (hsync_end_o),
        .hpulse_end_o  (hpulse_end_o),
        .hdata_begin_o (hdata_begin_o),
        .hdata_end_o   (hdata_end_o),
        .vsync_end_o   (vsync_end_o),
        .vpulse_end_o  (vpulse_end_o),
        .vdata_begin_o (vdata_begin_o),
        .vdata_end_o   (vdata_end_o),
        .base_addr_o   (base_addr_o),
        .top_addr_o    (top_addr_o),
        .self_test_o   (self_test_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer; fs drives frame_start_i during the completing cycle.
    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic fs, output logic [31:0] rd, output logic err);
        apb.psel_i    = 1'b1;
        apb.penable_i = 1'b0;
        apb.pwrite_i  = wr;
        apb.paddr_i   = a;
        apb.pwdata_i  = d;
        tick();
        apb.penable_i = 1'b1;
        chk("pready_first_access", 32'(apb.pready_o), 32'd0);
        tick();
        chk("pready_second_access", 32'(apb.pready_o), 32'd1);
        rd  = apb.prdata_o;
        err = apb.pslverr_o;
        frame_start_i = fs;
        tick();
        frame_start_i = 1'b0;
        apb.psel_i    = 1'b0;
        apb.penable_i = 1'b0;
        apb.pwrite_i  = 1'b0;
        chk("pready_drop", 32'(apb.pready_o), 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic fs = 1'b0);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, a, d, fs, rd, err);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b0, a, 32'd0, 1'b0, rd, err);
        chk(tag, rd, exp);
        chk({tag, "_slverr"}, 32'(err), 32'd0);
    endtask

    task automatic err_chk(input string tag, input logic w, input logic [31:0] a);
        logic [31:0] rd;
        logic        err;
        apb_xfer(w, a, 32'hFFFF_FFFF, 1'b0, rd, err);
        chk({tag, "_slverr"}, 32'(err), 32'd1);
        chk({tag, "_rdata"}, rd, 32'd0);
    endtask

    task automatic frame_pulse();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    initial begin
        resetn        = 1'b0;
        frame_start_i = 1'b0;
        apb.psel_i    = 1'b0;
        apb.penable_i = 1'b0;
        apb.pwrite_i  = 1'b0;
        apb.paddr_i   = '0;
        apb.pwdata_i  = '0;
        tick();
        tick();
        chk("rst_pready", 32'(apb.pready_o), 32'd0);
        chk("rst_pslverr", 32'(apb.pslverr_o), 32'd0);
        chk("rst_prdata", apb.prdata_o, 32'd0);
        chk("rst_hsync_end", 32'(hsync_end_o), 32'd799);
        chk("rst_vdata_end", 32'(vdata_end_o), 32'd514);
        chk("rst_top_addr", top_addr_o, 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        resetn = 1'b1;
        tick();

        rd_chk("mode0_h0", 32'h100, 32'h005F_031F);
        rd_chk("mode0_h1", 32'h104, 32'h030F_008F);
        rd_chk("mode0_v0", 32'h108, 32'h0001_020C);
        rd_chk("mode0_v1", 32'h10C, 32'h0202_0022);

        // Frame-synchronous commit of mode 1.
        wr(32'h110, 32'h0080_041F);
        wr(32'h000, 32'h0000_0102);
        wr(32'h014, 32'h0000_0001);
        chk("sync_hold_hsync", 32'(hsync_end_o), 32'd799);
        rd_chk("status_pending", 32'h00C, 32'h1);
        rd_chk("ctrl_readback", 32'h000, 32'h102);
        chk("sync_hold_hsync2", 32'(hsync_end_o), 32'd799);
        frame_pulse();
        chk("sync_out_lag", 32'(hsync_end_o), 32'd799);
        tick();
        chk("sync_hsync_end", 32'(hsync_end_o), 32'd1055);
        chk("sync_hpulse_end", 32'(hpulse_end_o), 32'd128);
        rd_chk("status_applied", 32'h00C, 32'h2);
        chk("irq_masked", 32'(irq_o), 32'd0);
        wr(32'h010, 32'h1);
        chk("irq_enabled", 32'(irq_o), 32'd1);
        wr(32'h00C, 32'h2);
        chk("irq_w1c", 32'(irq_o), 32'd0);
        rd_chk("status_cleared", 32'h00C, 32'h0);

        // Immediate commit with wrap-around top address.
        wr(32'h000, 32'h0);
        wr(32'h004, 32'h8000_0000);
        wr(32'h008, 32'h9000_0000);
        wr(32'h014, 32'h1);
        chk("async_top_e0", top_addr_o, 32'h0);
        tick();
        chk("async_top_e1", top_addr_o, 32'h0);
        tick();
        chk("async_top_e2", top_addr_o, 32'h1000_0000);
        chk("async_base", base_addr_o, 32'h8000_0000);
        chk("async_hsync_mode0", 32'(hsync_end_o), 32'd799);
        rd_chk("async_status", 32'h00C, 32'h2);

        // Commit coincident with a frame pulse must wait for the next pulse.
        wr(32'h00C, 32'h2);
        wr(32'h000, 32'h102);
        wr(32'h014, 32'h1, 1'b1);
        tick();
        tick();
        chk("coinc_no_apply", 32'(hsync_end_o), 32'd799);
        rd_chk("coinc_pending", 32'h00C, 32'h1);
        wr(32'h00C, 32'h2, 1'b1);
        rd_chk("w1c_vs_apply", 32'h00C, 32'h2);
        chk("coinc_applied_hsync", 32'(hsync_end_o), 32'd1055);
        chk("coinc_irq", 32'(irq_o), 32'd1);

        // Frame pulse without pending must not pick up staged edits.
        wr(32'h110, 32'h0060_0500);
        frame_pulse();
        tick();
        chk("idle_frame_hsync", 32'(hsync_end_o), 32'd1055);
        rd_chk("staged_h0", 32'h110, 32'h0060_0500);
        wr(32'h118, 32'hFFFF_FFFF);
        rd_chk("v_field_mask", 32'h118, 32'h07FF_07FF);

        // Decode errors.
        err_chk("rd_0x200", 1'b0, 32'h200);
        err_chk("wr_0x200", 1'b1, 32'h200);
        err_chk("wr_0x06", 1'b1, 32'h006);
        err_chk("rd_0x18", 1'b0, 32'h018);
        err_chk("wr_0x140", 1'b1, 32'h140);
        rd_chk("base_unchanged", 32'h004, 32'h8000_0000);
        rd_chk("mode1_unchanged", 32'h110, 32'h0060_0500);

        // Reset in the middle of a transfer with an update pending.
        wr(32'h014, 32'h1);
        apb.psel_i    = 1'b1;
        apb.penable_i = 1'b0;
        apb.pwrite_i  = 1'b0;
        apb.paddr_i   = 32'h00C;
        tick();
        apb.penable_i = 1'b1;
        tick();
        chk("midxfer_pready", 32'(apb.pready_o), 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_pready", 32'(apb.pready_o), 32'd0);
        chk("arst_hsync", 32'(hsync_end_o), 32'd799);
        chk("arst_top", top_addr_o, 32'd0);
        chk("arst_irq", 32'(irq_o), 32'd0);
        apb.psel_i    = 1'b0;
        apb.penable_i = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        rd_chk("arst_status", 32'h00C, 32'h0);
        rd_chk("arst_mode1", 32'h110, 32'h005F_031F);
        rd_chk("arst_ctrl", 32'h000, 32'h0);
        rd_chk("arst_base", 32'h004, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
